rename_tracker: RTL and testbench
=================================

# rename_tracker

Parametrised per-architectural-register rename state block for the CrackCore backend. Each architectural register owns RN_DEPTH physical slots; the block tracks the committed slot, the speculatively active slot, slot occupancy and write-back completion. It serves multi-channel rename, write-back and commit ports per cycle, answers operand-readiness queries, and restores speculative state on flush. It sits between the dispatch/rename stage and the commit stage, ahead of the physical register file.

## Interface
- ARCH_NUM, 32, number of architectural registers; index 0 is hard-wired zero.
- RN_DEPTH, 4, physical slots per architectural register; power of two, at least 2.
- RN_PORTS, 2, rename channels per cycle.
- WB_PORTS, 3, write-back channels per cycle.
- CMT_PORTS, 2, commit channels per cycle.
- QRY_PORTS, 4, operand query channels.
- Derived: AW = clog2(ARCH_NUM), RB = clog2(RN_DEPTH).
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- flush  in  1  restore speculative state to committed state.
- rn_vld  in  RN_PORTS  rename request per channel.
- rn_rd  in  RN_PORTS*AW  destination architectural index.
- rn_rdy  out  RN_PORTS  channel accepted this cycle (combinational).
- rn_phy  out  RN_PORTS*RB  allocated slot, valid when rn_vld&rn_rdy.
- wb_vld / wb_rd / wb_phy  in  WB_PORTS / WB_PORTS*AW / WB_PORTS*RB  write-back done.
- cmt_vld / cmt_rd / cmt_phy  in  CMT_PORTS / CMT_PORTS*AW / CMT_PORTS*RB  commit, in program order by port index.
- qry_rs  in  QRY_PORTS*AW  source architectural index.
- qry_phy  out  QRY_PORTS*RB  active slot of qry_rs.
- qry_rdy  out  QRY_PORTS  write-back complete for that slot.

## Operation
- State per register i≥1: archi[i] (RB), rnAct[i] (RB), used[i] (RN_DEPTH), wbLog[i] (RN_DEPTH). Register 0 is constant: pointers 0, used 0, wbLog all-ones.
- Reset: archi=rnAct=0, used=wbLog=one-hot bit 0 for every i≥1.
- Rename: the candidate slot is the one after the current candidate pointer, modulo RN_DEPTH. The candidate pointer starts at rnAct[rd]. Channels are scanned 0 upward; a channel whose rd matches an earlier accepted channel continues from that channel's slot.
- A channel is accepted if its candidate slot has used=0 in registered state. A rejected channel forces rn_rdy=0 on every later channel (in-order rename).
- On acceptance: rnAct[rd] takes the last accepted slot; used is set and wbLog is cleared for each allocated slot.
- rd=0: always accepted (subject to in-order rule), rn_phy=0, no state change.
- Write-back: wbLog[wb_rd][wb_phy] is set. rd=0 is ignored. Write-back to an unused slot is illegal; the verification model flags it.
- Commit, applied in port order: used and wbLog of the old archi[rd] are cleared, and archi[rd] takes cmt_phy. For same-rd commits in one cycle, intermediate slots are freed and the last one is kept. rd=0 is ignored.
- Query: qry_phy=rnAct[qry_rs] and qry_rdy=wbLog[qry_rs][rnAct] from registered state. There is no same-cycle bypass.
- Flush: commits in the same cycle apply first. Then for each i, rnAct takes the new archi value, and used and wbLog take one-hot(new archi). Renames and write-backs in a flush cycle are dropped, and rn_rdy is forced to 0.
- Priority within a cycle: RST > flush > (commit, rename, write-back merged). Slots freed by commit become allocatable the next cycle only. Set/clear on the same slot in the same cycle cannot occur legally.

## Timing
- All state updates on the rising edge of CLK. rn_rdy, rn_phy, qry_phy and qry_rdy are combinational from registered state and the current inputs.
- Rename to visible rnAct: 1 cycle. Write-back to qry_rdy=1: 1 cycle. Commit to slot reusable: 1 cycle.
- Flush takes effect in 1 cycle. The next cycle shows rnAct==archi and exactly one used bit per register.
- RST asserted mid-operation returns all state to the reset values on the next edge, regardless of other inputs.
- Wrap-around: a slot index increments modulo RN_DEPTH. Full register (all slots used) causes rn_rdy=0 for that channel and all later ones.

## Structure
- Package rename_pkg holds the parameter defaults, the clog2-derived widths, and a packed struct for per-register state {archi, rnAct, used, wbLog}.
- Sub-module rename_slot_ctrl holds one register's state plus its set/clear merge. It is instantiated ARCH_NUM-1 times in a generate loop. The top level holds the port-ordered rename scan and the query muxes.

## Test plan
- Reset, then query x5 → qry_phy=0, qry_rdy=1. Rename x5 on channel 0 → rn_phy=1, next-cycle qry_phy=1, qry_rdy=0. Write-back x5/1 → qry_rdy=1 the following cycle.
- Both channels rename x7 in one cycle (depth 4, reset state) → rn_phy 1 and 2, rnAct[x7]=2. Third cycle rename x7 → slot 3. Fourth rename x7 → rn_rdy=0, and a channel-1 rename of x8 in the same cycle is also stalled.
- Commit x7/1 → slot 0 freed. Rename x7 the next cycle → rn_phy=0 (wrap-around).
- Rename x3 twice (slots 1, 2), commit x3/1 and flush in the same cycle → archi=1, rnAct=1, used=0b0010, wbLog=0b0010.
- Two commits x9/1 then x9/2 in one cycle → archi[x9]=2, slots 0 and 1 freed.
- RST asserted while renames and commits are pending → all registers return to slot 0 and renames in that cycle are not retained.

Source files
------------

// File: rtl/rename_pkg.sv
// rtl/rename_pkg.sv - default parameters, derived widths and per-register rename state type
package rename_pkg;

  localparam int DEF_ARCH_NUM  = 32;
  localparam int DEF_RN_DEPTH  = 4;
  localparam int DEF_RN_PORTS  = 2;
  localparam int DEF_WB_PORTS  = 3;
  localparam int DEF_CMT_PORTS = 2;
  localparam int DEF_QRY_PORTS = 4;

  localparam int ARCH_W = $clog2(DEF_ARCH_NUM);
  localparam int SLOT_W = $clog2(DEF_RN_DEPTH);

  typedef struct packed {
    logic [SLOT_W-1:0]       archi;
    logic [SLOT_W-1:0]       rnAct;
    logic [DEF_RN_DEPTH-1:0] used;
    logic [DEF_RN_DEPTH-1:0] wbLog;
  } regState_t;

  // Every real register starts on slot 0, which holds the committed, written-back value.
  localparam regState_t RESET_STATE = '{
    archi: '0,
    rnAct: '0,
    used:  DEF_RN_DEPTH'(1),
    wbLog: DEF_RN_DEPTH'(1)
  };

  // Register 0 never renames and always reads as ready.
  localparam regState_t ZERO_STATE = '{
    archi: '0,
    rnAct: '0,
    used:  '0,
    wbLog: '1
  };

  function automatic logic [DEF_RN_DEPTH-1:0] oneHot(input logic [SLOT_W-1:0] idx);
    logic [DEF_RN_DEPTH-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rename_tracker_if.sv
// rtl/rename_tracker_if.sv - rename, write-back, commit and query bus of the rename tracker
interface rename_tracker_if #(
  parameter int ARCH_NUM  = rename_pkg::DEF_ARCH_NUM,
  parameter int RN_DEPTH  = rename_pkg::DEF_RN_DEPTH,
  parameter int RN_PORTS  = rename_pkg::DEF_RN_PORTS,
  parameter int WB_PORTS  = rename_pkg::DEF_WB_PORTS,
  parameter int CMT_PORTS = rename_pkg::DEF_CMT_PORTS,
  parameter int QRY_PORTS = rename_pkg::DEF_QRY_PORTS
);
  localparam int AW = $clog2(ARCH_NUM);
  localparam int RB = $clog2(RN_DEPTH);

  logic                      flush;
  logic [RN_PORTS-1:0]       rn_vld;
  logic [RN_PORTS*AW-1:0]    rn_rd;
  logic [RN_PORTS-1:0]       rn_rdy;
  logic [RN_PORTS*RB-1:0]    rn_phy;
  logic [WB_PORTS-1:0]       wb_vld;
  logic [WB_PORTS*AW-1:0]    wb_rd;
  logic [WB_PORTS*RB-1:0]    wb_phy;
  logic [CMT_PORTS-1:0]      cmt_vld;
  logic [CMT_PORTS*AW-1:0]   cmt_rd;
  logic [CMT_PORTS*RB-1:0]   cmt_phy;
  logic [QRY_PORTS*AW-1:0]   qry_rs;
  logic [QRY_PORTS*RB-1:0]   qry_phy;
  logic [QRY_PORTS-1:0]      qry_rdy;

  modport master (
    output flush, rn_vld, rn_rd, wb_vld, wb_rd, wb_phy, cmt_vld, cmt_rd, cmt_phy, qry_rs,
    input  rn_rdy, rn_phy, qry_phy, qry_rdy
  );

  modport slave (
    input  flush, rn_vld, rn_rd, wb_vld, wb_rd, wb_phy, cmt_vld, cmt_rd, cmt_phy, qry_rs,
    output rn_rdy, rn_phy, qry_phy, qry_rdy
  );

endinterface

// File: rtl/rename_slot_ctrl.sv
// rtl/rename_slot_ctrl.sv - rename state of one architectural register with its set/clear merge
module rename_slot_ctrl
  import rename_pkg::*;
#(
  parameter int IDX       = 1,
  parameter int ARCH_NUM  = DEF_ARCH_NUM,
  parameter int RN_DEPTH  = DEF_RN_DEPTH,
  parameter int RN_PORTS  = DEF_RN_PORTS,
  parameter int WB_PORTS  = DEF_WB_PORTS,
  parameter int CMT_PORTS = DEF_CMT_PORTS,
  localparam int AW = $clog2(ARCH_NUM),
  localparam int RB = $clog2(RN_DEPTH)
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    flush,
  input  logic [RN_PORTS-1:0]     rnFire,
  input  logic [RN_PORTS*AW-1:0]  rnRd,
  input  logic [RN_PORTS*RB-1:0]  rnPhy,
  input  logic [WB_PORTS-1:0]     wbVld,
  input  logic [WB_PORTS*AW-1:0]  wbRd,
  input  logic [WB_PORTS*RB-1:0]  wbPhy,
  input  logic [CMT_PORTS-1:0]    cmtVld,
  input  logic [CMT_PORTS*AW-1:0] cmtRd,
  input  logic [CMT_PORTS*RB-1:0] cmtPhy,
  output regState_t               state
);

  localparam logic [AW-1:0] MY_IDX = AW'(IDX);

  regState_t           stQ;
  regState_t           stD;
  logic [RN_DEPTH-1:0] renMask;
  logic [RN_DEPTH-1:0] wbMask;
  logic [RN_DEPTH-1:0] freeMask;
  logic [RB-1:0]       renLast;
  logic [RB-1:0]       newArchi;

  // Merge this cycle's commits, renames and write-backs aimed at this register into the next state.
  always_comb begin
    renMask  = '0;
    wbMask   = '0;
    freeMask = '0;
    renLast  = stQ.rnAct;
    newArchi = stQ.archi;

    for (int p = 0; p < RN_PORTS; p++) begin
      if (rnFire[p] && rnRd[p*AW +: AW] == MY_IDX) begin
        renMask[rnPhy[p*RB +: RB]] = 1'b1;
        renLast                    = rnPhy[p*RB +: RB];
      end
    end

    for (int w = 0; w < WB_PORTS; w++) begin
      if (wbVld[w] && wbRd[w*AW +: AW] == MY_IDX) begin
        wbMask[wbPhy[w*RB +: RB]] = 1'b1;
      end
    end

    // Commits chain in port order: each one retires the previous committed slot.
    for (int c = 0; c < CMT_PORTS; c++) begin
      if (cmtVld[c] && cmtRd[c*AW +: AW] == MY_IDX) begin
        freeMask[newArchi] = 1'b1;
        newArchi           = cmtPhy[c*RB +: RB];
      end
    end

    stD       = stQ;
    stD.archi = newArchi;
    if (flush) begin
      stD.rnAct = newArchi;
      stD.used  = oneHot(newArchi);
      stD.wbLog = oneHot(newArchi);
    end else begin
      stD.rnAct = renLast;
      stD.used  = (stQ.used & ~freeMask) | renMask;
      stD.wbLog = (stQ.wbLog & ~freeMask & ~renMask) | wbMask;
    end
  end

  // State register; reset overrides every other request.
  always_ff @(posedge CLK) begin
    if (RST) begin
      stQ <= RESET_STATE;
    end else begin
      stQ <= stD;
    end
  end

  assign state = stQ;

endmodule

// File: rtl/rename_tracker.sv
// rtl/rename_tracker.sv - per-architectural-register rename tracker with in-order rename scan and queries
module rename_tracker
  import rename_pkg::*;
#(
  parameter int ARCH_NUM  = DEF_ARCH_NUM,
  parameter int RN_DEPTH  = DEF_RN_DEPTH,
  parameter int RN_PORTS  = DEF_RN_PORTS,
  parameter int WB_PORTS  = DEF_WB_PORTS,
  parameter int CMT_PORTS = DEF_CMT_PORTS,
  parameter int QRY_PORTS = DEF_QRY_PORTS
) (
  input logic             CLK,
  input logic             RST,
  rename_tracker_if.slave bus
);

  localparam int AW = $clog2(ARCH_NUM);
  localparam int RB = $clog2(RN_DEPTH);

  regState_t [ARCH_NUM-1:0] regSt;
  logic [RN_PORTS-1:0]      rnRdy;
  logic [RN_PORTS-1:0]      rnFire;
  logic [RN_PORTS*RB-1:0]   rnSlot;
  logic                     scanStall;
  logic                     scanOk;
  logic [AW-1:0]            scanRd;
  logic [RB-1:0]            scanCand;
  logic [RB-1:0]            scanNext;
  logic [AW-1:0]            qryIdx;
  regState_t                qrySt;

  assign regSt[0] = ZERO_STATE;

  // Scan rename channels in order; a same-rd channel continues from the slot its predecessor took.
  always_comb begin
    rnRdy     = '0;
    rnSlot    = '0;
    scanStall = 1'b0;
    scanOk    = 1'b0;
    scanRd    = '0;
    scanCand  = '0;
    scanNext  = '0;
    for (int p = 0; p < RN_PORTS; p++) begin
      scanRd   = bus.rn_rd[p*AW +: AW];
      scanCand = regSt[scanRd].rnAct;
      for (int q = 0; q < p; q++) begin
        if (bus.rn_vld[q] && rnRdy[q] && bus.rn_rd[q*AW +: AW] == scanRd) begin
          scanCand = rnSlot[q*RB +: RB];
        end
      end
      scanNext = scanCand + RB'(1);
      if (scanRd == '0) begin
        scanOk               = 1'b1;
        rnSlot[p*RB +: RB]   = '0;
      end else begin
        scanOk               = !regSt[scanRd].used[scanNext];
        rnSlot[p*RB +: RB]   = scanNext;
      end
      rnRdy[p] = scanOk && !scanStall && !bus.flush;
      if (bus.rn_vld[p] && !rnRdy[p]) begin
        scanStall = 1'b1;
      end
    end
  end

  assign bus.rn_rdy = rnRdy;
  assign bus.rn_phy = rnSlot;
  assign rnFire     = bus.rn_vld & rnRdy;

  // Operand queries read registered state only; no same-cycle bypass.
  always_comb begin
    bus.qry_phy = '0;
    bus.qry_rdy = '0;
    qryIdx      = '0;
    qrySt       = ZERO_STATE;
    for (int q = 0; q < QRY_PORTS; q++) begin
      qryIdx                  = bus.qry_rs[q*AW +: AW];
      qrySt                   = regSt[qryIdx];
      bus.qry_phy[q*RB +: RB] = qrySt.rnAct;
      bus.qry_rdy[q]          = qrySt.wbLog[qrySt.rnAct];
    end
  end

  for (genvar i = 1; i < ARCH_NUM; i++) begin : gen_slot
    rename_slot_ctrl #(
      .IDX      (i),
      .ARCH_NUM (ARCH_NUM),
      .RN_DEPTH (RN_DEPTH),
      .RN_PORTS (RN_PORTS),
      .WB_PORTS (WB_PORTS),
      .CMT_PORTS(CMT_PORTS)
    ) u_slot (
      .CLK    (CLK),
      .RST    (RST),
      .flush  (bus.flush),
      .rnFire (rnFire),
      .rnRd   (bus.rn_rd),
      .rnPhy  (rnSlot),
      .wbVld  (bus.wb_vld),
      .wbRd   (bus.wb_rd),
      .wbPhy  (bus.wb_phy),
      .cmtVld (bus.cmt_vld),
      .cmtRd  (bus.cmt_rd),
      .cmtPhy (bus.cmt_phy),
      .state  (regSt[i])
    );
  end

endmodule

// File: tb/tb_rename_tracker.sv
// tb/tb_rename_tracker.sv - self-checking bench for rename_tracker with a slot-set reference model
module tb_rename_tracker;

  localparam int D = 4;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   nVec = 0;
  int   nMis = 0;

  int       mArchi [32];
  int       mAct   [32];
  bit [3:0] mUsed  [32];
  bit [3:0] mWb    [32];

  rename_tracker_if bus ();

  rename_tracker dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush   = 1'b0;
    bus.rn_vld  = '0;
    bus.rn_rd   = '0;
    bus.wb_vld  = '0;
    bus.wb_rd   = '0;
    bus.wb_phy  = '0;
    bus.cmt_vld = '0;
    bus.cmt_rd  = '0;
    bus.cmt_phy = '0;
    bus.qry_rs  = '0;
  endtask

  task automatic set_rn(input int p, input int rd);
    bus.rn_vld[p]       = 1'b1;
    bus.rn_rd[p*5 +: 5] = 5'(rd);
  endtask

  task automatic set_cmt(input int c, input int rd, input int phy);
    bus.cmt_vld[c]       = 1'b1;
    bus.cmt_rd[c*5 +: 5] = 5'(rd);
    bus.cmt_phy[c*2 +: 2] = 2'(phy);
  endtask

  task automatic set_wb(input int w, input int rd, input int phy);
    bus.wb_vld[w]       = 1'b1;
    bus.wb_rd[w*5 +: 5] = 5'(rd);
    bus.wb_phy[w*2 +: 2] = 2'(phy);
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    for (int i = 0; i < 32; i++) begin
      mArchi[i] = 0;
      mAct[i]   = 0;
      mUsed[i]  = (i == 0) ? 4'b0000 : 4'b0001;
      mWb[i]    = (i == 0) ? 4'b1111 : 4'b0001;
    end
  endtask

  task automatic test_reset();
    int rs [4];
    rs = '{5, 0, 31, 1};
    do_reset();
    for (int q = 0; q < 4; q++) bus.qry_rs[q*5 +: 5] = 5'(rs[q]);
    #1;
    for (int q = 0; q < 4; q++) begin
      nVec++;
      if (bus.qry_phy[q*2 +: 2] !== 2'd0) begin
        nMis++; $display("FAIL reset_qry_phy x%0d: got %0d want 0", rs[q], bus.qry_phy[q*2 +: 2]);
      end
      nVec++;
      if (bus.qry_rdy[q] !== 1'b1) begin
        nMis++; $display("FAIL reset_qry_rdy x%0d: got %b want 1", rs[q], bus.qry_rdy[q]);
      end
    end
  endtask

  task automatic test_basic();
    do_reset();
    set_rn(0, 5);
    #1;
    nVec++;
    if (bus.rn_rdy[0] !== 1'b1) begin nMis++; $display("FAIL basic_rdy: got %b want 1", bus.rn_rdy[0]); end
    nVec++;
    if (bus.rn_phy[1:0] !== 2'd1) begin nMis++; $display("FAIL basic_phy: got %0d want 1", bus.rn_phy[1:0]); end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd5;
    set_wb(0, 5, 1);
    #1;
    nVec++;
    if (bus.qry_phy[1:0] !== 2'd1) begin nMis++; $display("FAIL basic_qry_phy: got %0d want 1", bus.qry_phy[1:0]); end
    nVec++;
    if (bus.qry_rdy[0] !== 1'b0) begin nMis++; $display("FAIL basic_qry_nobypass: got %b want 0", bus.qry_rdy[0]); end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd5;
    #1;
    nVec++;
    if (bus.qry_rdy[0] !== 1'b1) begin nMis++; $display("FAIL basic_qry_wb: got %b want 1", bus.qry_rdy[0]); end
  endtask

  task automatic test_dual_rename();
    do_reset();
    set_rn(0, 7);
    set_rn(1, 7);
    #1;
    nVec++;
    if (bus.rn_rdy !== 2'b11) begin nMis++; $display("FAIL dual_rdy: got %b want 11", bus.rn_rdy); end
    nVec++;
    if (bus.rn_phy !== 4'b10_01) begin nMis++; $display("FAIL dual_phy: got %b want 1001", bus.rn_phy); end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd7;
    set_rn(0, 7);
    #1;
    nVec++;
    if (bus.qry_phy[1:0] !== 2'd2) begin nMis++; $display("FAIL dual_act: got %0d want 2", bus.qry_phy[1:0]); end
    nVec++;
    if (bus.rn_rdy[0] !== 1'b1 || bus.rn_phy[1:0] !== 2'd3) begin
      nMis++; $display("FAIL third_rename: got rdy %b phy %0d want rdy 1 phy 3", bus.rn_rdy[0], bus.rn_phy[1:0]);
    end
    tick();
    clear_inputs();
    set_rn(0, 7);
    set_rn(1, 8);
    #1;
    nVec++;
    if (bus.rn_rdy !== 2'b00) begin nMis++; $display("FAIL full_stall: got %b want 00", bus.rn_rdy); end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd7;
    bus.qry_rs[9:5] = 5'd8;
    #1;
    nVec++;
    if (bus.qry_phy[3:0] !== 4'b00_11) begin nMis++; $display("FAIL stall_state: got %b want 0011", bus.qry_phy[3:0]); end
  endtask

  task automatic test_wrap();
    clear_inputs();
    set_cmt(0, 7, 1);
    set_rn(0, 7);
    #1;
    nVec++;
    if (bus.rn_rdy[0] !== 1'b0) begin nMis++; $display("FAIL wrap_same_cycle: got %b want 0", bus.rn_rdy[0]); end
    tick();
    clear_inputs();
    set_rn(0, 7);
    #1;
    nVec++;
    if (bus.rn_rdy[0] !== 1'b1 || bus.rn_phy[1:0] !== 2'd0) begin
      nMis++; $display("FAIL wrap_rename: got rdy %b phy %0d want rdy 1 phy 0", bus.rn_rdy[0], bus.rn_phy[1:0]);
    end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd7;
    #1;
    nVec++;
    if (bus.qry_phy[1:0] !== 2'd0) begin nMis++; $display("FAIL wrap_act: got %0d want 0", bus.qry_phy[1:0]); end
  endtask

  task automatic test_flush();
    do_reset();
    set_rn(0, 3);
    set_rn(1, 3);
    tick();
    clear_inputs();
    set_cmt(0, 3, 1);
    bus.flush = 1'b1;
    set_rn(0, 4);
    set_wb(0, 3, 2);
    #1;
    nVec++;
    if (bus.rn_rdy !== 2'b00) begin nMis++; $display("FAIL flush_rdy: got %b want 00", bus.rn_rdy); end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd3;
    bus.qry_rs[9:5] = 5'd4;
    #1;
    nVec++;
    if (bus.qry_phy[1:0] !== 2'd1 || bus.qry_rdy[0] !== 1'b1) begin
      nMis++; $display("FAIL flush_x3: got phy %0d rdy %b want phy 1 rdy 1", bus.qry_phy[1:0], bus.qry_rdy[0]);
    end
    nVec++;
    if (bus.qry_phy[3:2] !== 2'd0) begin nMis++; $display("FAIL flush_drop_rename: got %0d want 0", bus.qry_phy[3:2]); end
    set_rn(0, 3);
    set_rn(1, 3);
    #1;
    nVec++;
    if (bus.rn_rdy !== 2'b11 || bus.rn_phy !== 4'b11_10) begin
      nMis++; $display("FAIL flush_used: got rdy %b phy %b want 11 1110", bus.rn_rdy, bus.rn_phy);
    end
    tick();
    clear_inputs();
    bus.qry_rs[4:0] = 5'd3;
    #1;
    nVec++;
    if (bus.qry_phy[1:0] !== 2'd3 || bus.qry_rdy[0] !== 1'b0) begin
      nMis++; $display("FAIL flush_after: got phy %0d rdy %b want phy 3 rdy 0", bus.qry_phy[1:0], bus.qry_rdy[0]);
    end
  endtask

  task automatic test_double_commit();
    do_reset();
    set_rn(0, 9);
    set_rn(1, 9);
    tick();
    clear_inputs();
    set_cmt(0, 9, 1);
    set_cmt(1, 9, 2);
    tick();
    clear_inputs();
    set_rn(0, 9);
    set_rn(1, 9);
    #1;
    nVec++;
    if (bus.rn_rdy !== 2'b11 || bus.rn_phy !== 4'b00_11) begin
      nMis++; $display("FAIL dcommit_free0: got rdy %b phy %b want 11 0011", bus.rn_rdy, bus.rn_phy);
    end
    tick();
    clear_inputs();
    set_rn(0, 9);
    #1;
    nVec++;
    if (bus.rn_rdy[0] !== 1'b1 || bus.rn_phy[1:0] !== 2'd1) begin
      nMis++; $display("FAIL dcommit_free1: got rdy %b phy %0d want 1 1", bus.rn_rdy[0], bus.rn_phy[1:0]);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    int rs [4];
    rs = '{9, 10, 11, 3};
    clear_inputs();
    set_rn(0, 10);
    set_rn(1, 11);
    set_cmt(0, 9, 3);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    clear_inputs();
    for (int q = 0; q < 4; q++) bus.qry_rs[q*5 +: 5] = 5'(rs[q]);
    set_rn(0, 9);
    #1;
    for (int q = 0; q < 4; q++) begin
      nVec++;
      if (bus.qry_phy[q*2 +: 2] !== 2'd0 || bus.qry_rdy[q] !== 1'b1) begin
        nMis++; $display("FAIL rst_mid x%0d: got phy %0d rdy %b want 0 1", rs[q], bus.qry_phy[q*2 +: 2], bus.qry_rdy[q]);
      end
    end
    nVec++;
    if (bus.rn_rdy[0] !== 1'b1 || bus.rn_phy[1:0] !== 2'd1) begin
      nMis++; $display("FAIL rst_mid_rename: got rdy %b phy %0d want 1 1", bus.rn_rdy[0], bus.rn_phy[1:0]);
    end
    tick();
  endtask

  task automatic test_random(input int cycles);
    int       tArchi [32];
    bit [3:0] freed  [32];
    int       pend   [32];
    int       slotOf [2];
    bit       fire   [2];
    bit       stall;
    bit       ok;
    bit       expRdy;
    int       r;
    int       s;
    int       slot;
    do_reset();
    for (int n = 0; n < cycles; n++) begin
      clear_inputs();
      for (int i = 0; i < 32; i++) begin
        tArchi[i] = mArchi[i];
        freed[i]  = '0;
        pend[i]   = mAct[i];
      end
      bus.flush = ($urandom_range(0, 31) == 0);
      // commits retire the oldest in-flight slot of a register
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          if (r == 0) begin
            set_cmt(c, 0, $urandom_range(0, 3));
          end else begin
            s = (tArchi[r] + 1) % D;
            if (mUsed[r][s]) begin
              set_cmt(c, r, s);
              freed[r][tArchi[r]] = 1'b1;
              tArchi[r] = s;
            end
          end
        end
      end
      // write-backs to slots that are not occupied are illegal and are suppressed
      for (int w = 0; w < 3; w++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          s = $urandom_range(0, 3);
          if (r == 0 || (mUsed[r][s] && !freed[r][s])) set_wb(w, r, s);
        end
      end
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) != 0) set_rn(p, $urandom_range(0, 7));
        else bus.rn_rd[p*5 +: 5] = 5'($urandom_range(0, 7));
      end
      for (int q = 0; q < 4; q++) bus.qry_rs[q*5 +: 5] = 5'($urandom_range(0, 9));
      #1;
      stall = 1'b0;
      for (int p = 0; p < 2; p++) begin
        r    = int'(bus.rn_rd[p*5 +: 5]);
        slot = (r == 0) ? 0 : (pend[r] + 1) % D;
        ok   = (r == 0) || !mUsed[r][slot];
        expRdy = ok && !stall && !bus.flush;
        fire[p]   = bus.rn_vld[p] && expRdy;
        slotOf[p] = slot;
        nVec++;
        if (bus.rn_rdy[p] !== expRdy) begin
          nMis++; $display("FAIL rand_rn_rdy cyc%0d ch%0d x%0d: got %b want %b", n, p, r, bus.rn_rdy[p], expRdy);
        end
        if (fire[p]) begin
          nVec++;
          if (int'(bus.rn_phy[p*2 +: 2]) != slot) begin
            nMis++; $display("FAIL rand_rn_phy cyc%0d ch%0d x%0d: got %0d want %0d", n, p, r, bus.rn_phy[p*2 +: 2], slot);
          end
          if (r != 0) pend[r] = slot;
        end
        if (bus.rn_vld[p] && !expRdy) stall = 1'b1;
      end
      for (int q = 0; q < 4; q++) begin
        r = int'(bus.qry_rs[q*5 +: 5]);
        nVec++;
        if (int'(bus.qry_phy[q*2 +: 2]) != mAct[r] || bus.qry_rdy[q] !== mWb[r][mAct[r]]) begin
          nMis++; $display("FAIL rand_qry cyc%0d x%0d: got phy %0d rdy %b want phy %0d rdy %b",
                           n, r, bus.qry_phy[q*2 +: 2], bus.qry_rdy[q], mAct[r], mWb[r][mAct[r]]);
        end
      end
      for (int c = 0; c < 2; c++) begin
        r = int'(bus.cmt_rd[c*5 +: 5]);
        if (bus.cmt_vld[c] && r != 0) begin
          mUsed[r][mArchi[r]] = 1'b0;
          mWb[r][mArchi[r]]   = 1'b0;
          mArchi[r]           = int'(bus.cmt_phy[c*2 +: 2]);
        end
      end
      if (bus.flush) begin
        for (int i = 1; i < 32; i++) begin
          mAct[i]  = mArchi[i];
          mUsed[i] = 4'(1 << mArchi[i]);
          mWb[i]   = 4'(1 << mArchi[i]);
        end
      end else begin
        for (int p = 0; p < 2; p++) begin
          r = int'(bus.rn_rd[p*5 +: 5]);
          if (fire[p] && r != 0) begin
            mUsed[r][slotOf[p]] = 1'b1;
            mWb[r][slotOf[p]]   = 1'b0;
            mAct[r]             = slotOf[p];
          end
        end
        for (int w = 0; w < 3; w++) begin
          r = int'(bus.wb_rd[w*5 +: 5]);
          if (bus.wb_vld[w] && r != 0) mWb[r][bus.wb_phy[w*2 +: 2]] = 1'b1;
        end
      end
      tick();
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_basic();
    test_dual_rename();
    test_wrap();
    test_flush();
    test_double_commit();
    test_rst_mid();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
